// File: rtl/billiard_pkg.sv
// Shared types and constants for the billiard table blocks: shot FSM states,
// fixed-point scale, velocity limit and the 16-step direction tables.
package billiard_pkg;

    typedef enum logic [2:0] {
        WAIT_STOP,
        AIM,
        CHARGE,
        FIRE,
        WAIT_MOVE
    } shot_state_t;

    localparam int FIXED_POINT_MULTIPLIER = 64;
    localparam int VELOCITY_LIMIT         = 200;

    // Unit vectors scaled by 64, index 0 = +X, counter-clockwise, +Y = screen down.
    localparam logic signed [7:0] COS_TABLE [16] = '{
        8'sd64,  8'sd59,  8'sd45,  8'sd24,  8'sd0,  -8'sd24, -8'sd45, -8'sd59,
        -8'sd64, -8'sd59, -8'sd45, -8'sd24, 8'sd0,   8'sd24,  8'sd45,  8'sd59
    };
    localparam logic signed [7:0] SIN_TABLE [16] = '{
        8'sd0,   8'sd24,  8'sd45,  8'sd59,  8'sd64,  8'sd59,  8'sd45,  8'sd24,
        8'sd0,  -8'sd24, -8'sd45, -8'sd59, -8'sd64, -8'sd59, -8'sd45, -8'sd24
    };

    // power * coef / 64, signed division truncating toward zero; |result| <= 200.
    function automatic logic signed [10:0] scale_velocity(
        input logic        [7:0] power,
        input logic signed [7:0] coef
    );
        logic signed [16:0] product;
        product = $signed({9'd0, power}) * $signed({{9{coef[7]}}, coef});
        return 11'(product / $signed(17'(FIXED_POINT_MULTIPLIER)));
    endfunction

endpackage

// File: rtl/shot_controller_if.sv
// Control/velocity bundle between the player-input side and the shot controller.
interface shot_controller_if;

    logic               startOfFrame;
    logic               allStopped;
    logic               aimLeft;
    logic               aimRight;
    logic               shootButton;
    logic               velocityWriteEnable;
    logic signed [10:0] outVelocityX;
    logic signed [10:0] outVelocityY;
    logic        [3:0]  aimIndex;
    logic        [7:0]  power;
    logic               shotReady;
    logic        [7:0]  shotCount;

    modport master (
        output startOfFrame, allStopped, aimLeft, aimRight, shootButton,
        input  velocityWriteEnable, outVelocityX, outVelocityY,
               aimIndex, power, shotReady, shotCount
    );

    modport slave (
        input  startOfFrame, allStopped, aimLeft, aimRight, shootButton,
        output velocityWriteEnable, outVelocityX, outVelocityY,
               aimIndex, power, shotReady, shotCount
    );

endinterface

// File: rtl/shot_direction_rom.sv
// Combinational 16-entry direction lookup: aim index to signed cos/sin (x64).
module shot_direction_rom
    import billiard_pkg::*;
(
    input  logic        [3:0] index,
    output logic signed [7:0] cosValue,
    output logic signed [7:0] sinValue
);

    assign cosValue = COS_TABLE[index];
    assign sinValue = SIN_TABLE[index];

endmodule

// File: rtl/shot_controller.sv
// Cue shot controller: waits for the table to settle, handles aim and power
// charge, then issues one velocity load to the cue-ball motion block.
module shot_controller
    import billiard_pkg::*;
#(
    parameter int POWER_MAX           = VELOCITY_LIMIT,
    parameter int POWER_STEP          = 4,
    parameter int AIM_FRAMES          = 6,
    parameter int MOVE_TIMEOUT_FRAMES = 2
) (
    input  logic            clk,
    input  logic            reset,
    shot_controller_if.slave bus
);

    localparam logic [8:0] POWER_MAX_W  = 9'(POWER_MAX);
    localparam logic [8:0] POWER_STEP_W = 9'(POWER_STEP);
    localparam logic [7:0] AIM_LAST     = 8'(AIM_FRAMES - 1);
    localparam logic [7:0] MOVE_LAST    = 8'(MOVE_TIMEOUT_FRAMES - 1);

    shot_state_t        state;
    logic        [3:0]  aimIndex;
    logic        [7:0]  power;
    logic        [7:0]  aimFrameCount;
    logic        [7:0]  moveFrameCount;
    logic        [7:0]  shotCount;
    logic               shotReady;
    logic               velocityWriteEnable;
    logic signed [10:0] velocityX;
    logic signed [10:0] velocityY;

    logic signed [7:0]  cosValue;
    logic signed [7:0]  sinValue;
    logic        [8:0]  powerSum;
    logic        [7:0]  powerNext;

    shot_direction_rom u_direction_rom (
        .index    (aimIndex),
        .cosValue (cosValue),
        .sinValue (sinValue)
    );

    assign powerSum  = {1'b0, power} + POWER_STEP_W;
    assign powerNext = (powerSum >= POWER_MAX_W) ? POWER_MAX_W[7:0] : powerSum[7:0];

    // NOTE: all state here is sequential, so every assignment in this block is
    // non-blocking; mixing in blocking writes would make results order-dependent.
    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= WAIT_STOP;
            aimIndex            <= '0;
            power               <= '0;
            aimFrameCount       <= '0;
            moveFrameCount      <= '0;
            shotCount           <= '0;
            shotReady           <= 1'b0;
            velocityWriteEnable <= 1'b0;
            velocityX           <= '0;
            velocityY           <= '0;
        end else begin
            velocityWriteEnable <= 1'b0;
            case (state)
                WAIT_STOP: begin
                    if (bus.allStopped) begin
                        state     <= AIM;
                        shotReady <= 1'b1;
                    end
                end
                AIM: begin
                    if (!bus.allStopped) begin
                        state         <= WAIT_STOP;
                        shotReady     <= 1'b0;
                        power         <= '0;
                        aimFrameCount <= '0;
                    end else if (bus.shootButton) begin
                        state         <= CHARGE;
                        power         <= '0;
                        aimFrameCount <= '0;
                    end else if (bus.aimLeft ^ bus.aimRight) begin
                        // Step on the first held frame, then once every AIM_FRAMES frames.
                        if (bus.startOfFrame) begin
                            if (aimFrameCount == '0)
                                aimIndex <= bus.aimRight ? aimIndex + 4'd1 : aimIndex - 4'd1;
                            aimFrameCount <= (aimFrameCount == AIM_LAST) ? '0 : aimFrameCount + 8'd1;
                        end
                    end else begin
                        aimFrameCount <= '0;
                    end
                end
                CHARGE: begin
                    if (!bus.allStopped) begin
                        state     <= WAIT_STOP;
                        shotReady <= 1'b0;
                        power     <= '0;
                    end else if (!bus.shootButton) begin
                        // Release wins over a coincident frame: the shot uses the current power.
                        state               <= FIRE;
                        shotReady           <= 1'b0;
                        velocityWriteEnable <= 1'b1;
                        velocityX           <= scale_velocity(power, cosValue);
                        velocityY           <= scale_velocity(power, sinValue);
                    end else if (bus.startOfFrame) begin
                        power <= powerNext;
                    end
                end
                FIRE: begin
                    shotCount      <= shotCount + 8'd1;
                    power          <= '0;
                    moveFrameCount <= '0;
                    if (velocityX == '0 && velocityY == '0) begin
                        state     <= AIM;
                        shotReady <= 1'b1;
                    end else begin
                        state <= WAIT_MOVE;
                    end
                end
                WAIT_MOVE: begin
                    if (!bus.allStopped) begin
                        state <= WAIT_STOP;
                    end else if (bus.startOfFrame) begin
                        if (moveFrameCount == MOVE_LAST)
                            state <= WAIT_STOP;
                        else
                            moveFrameCount <= moveFrameCount + 8'd1;
                    end
                end
                default: state <= WAIT_STOP;
            endcase
        end
    end

    assign bus.velocityWriteEnable = velocityWriteEnable;
    assign bus.outVelocityX        = velocityX;
    assign bus.outVelocityY        = velocityY;
    assign bus.aimIndex            = aimIndex;
    assign bus.power               = power;
    assign bus.shotReady           = shotReady;
    assign bus.shotCount           = shotCount;

endmodule

// File: tb/tb_shot_controller.sv
// Directed bench for shot_controller: aim stepping, a table of shots with
// hand-computed velocities, and the abort / reset-in-FIRE corner cases.
module tb_shot_controller;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   expAim;
    int   expCount;

    shot_controller_if bus ();

    shot_controller #(
        .POWER_MAX           (200),
        .POWER_STEP          (4),
        .AIM_FRAMES          (6),
        .MOVE_TIMEOUT_FRAMES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int aim;
        int frames;
        int expPower;
        int expX;
        int expY;
    } shot_vec_t;

    shot_vec_t vecs [6];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        bus.startOfFrame = 1'b1;
        tick();
        bus.startOfFrame = 1'b0;
        tick();
    endtask

    task automatic step_right_to(input int target);
        while (expAim != target) begin
            bus.aimRight = 1'b1;
            frame();
            bus.aimRight = 1'b0;
            tick();
            expAim = (expAim + 1) % 16;
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        expAim   = 0;
        expCount = 0;

        vecs[0] = '{aim: 0,  frames: 60, expPower: 200, expX: 200, expY: 0};
        vecs[1] = '{aim: 2,  frames: 25, expPower: 100, expX: 70,  expY: 70};
        vecs[2] = '{aim: 10, frames: 25, expPower: 100, expX: -70, expY: -70};
        vecs[3] = '{aim: 5,  frames: 11, expPower: 44,  expX: -16, expY: 40};
        vecs[4] = '{aim: 13, frames: 1,  expPower: 4,   expX: 1,   expY: -3};
        vecs[5] = '{aim: 13, frames: 0,  expPower: 0,   expX: 0,   expY: 0};

        bus.startOfFrame = 1'b0;
        bus.allStopped   = 1'b0;
        bus.aimLeft      = 1'b0;
        bus.aimRight     = 1'b0;
        bus.shootButton  = 1'b0;
        reset            = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();

        check("reset_wen",   int'(bus.velocityWriteEnable), 0);
        check("reset_vx",    int'(bus.outVelocityX), 0);
        check("reset_vy",    int'(bus.outVelocityY), 0);
        check("reset_aim",   int'(bus.aimIndex), 0);
        check("reset_power", int'(bus.power), 0);
        check("reset_ready", int'(bus.shotReady), 0);
        check("reset_count", int'(bus.shotCount), 0);

        bus.allStopped = 1'b1;
        tick();
        check("enter_aim_ready", int'(bus.shotReady), 1);

        // Aim auto-repeat: steps on frames 1, 7, 13.
        bus.aimRight = 1'b1;
        for (int f = 1; f <= 13; f++) begin
            frame();
            if (f == 1)  check("aim_right_f1",  int'(bus.aimIndex), 1);
            if (f == 6)  check("aim_right_f6",  int'(bus.aimIndex), 1);
            if (f == 7)  check("aim_right_f7",  int'(bus.aimIndex), 2);
            if (f == 13) check("aim_right_f13", int'(bus.aimIndex), 3);
        end
        bus.aimRight = 1'b0;
        tick();
        bus.aimLeft = 1'b1;
        for (int f = 1; f <= 13; f++) frame();
        check("aim_left_13", int'(bus.aimIndex), 0);
        bus.aimLeft = 1'b0;
        tick();
        bus.aimLeft = 1'b1;
        frame();
        check("aim_left_wrap", int'(bus.aimIndex), 15);
        bus.aimLeft = 1'b0;
        tick();
        bus.aimLeft  = 1'b1;
        bus.aimRight = 1'b1;
        for (int f = 0; f < 3; f++) frame();
        check("aim_both_hold", int'(bus.aimIndex), 15);
        bus.aimLeft  = 1'b0;
        bus.aimRight = 1'b0;
        tick();
        bus.aimRight = 1'b1;
        frame();
        bus.aimRight = 1'b0;
        tick();
        check("aim_right_wrap", int'(bus.aimIndex), 0);
        expAim = 0;

        // Table of shots.
        for (int i = 0; i < 6; i++) begin
            step_right_to(vecs[i].aim);
            check($sformatf("v%0d_aim", i), int'(bus.aimIndex), expAim);
            bus.shootButton = 1'b1;
            tick();
            for (int f = 0; f < vecs[i].frames; f++) frame();
            check($sformatf("v%0d_power", i), int'(bus.power), vecs[i].expPower);
            check($sformatf("v%0d_aim_frozen", i), int'(bus.aimIndex), expAim);
            bus.shootButton = 1'b0;
            tick();
            check($sformatf("v%0d_wen", i), int'(bus.velocityWriteEnable), 1);
            check($sformatf("v%0d_vx", i), int'(bus.outVelocityX), vecs[i].expX);
            check($sformatf("v%0d_vy", i), int'(bus.outVelocityY), vecs[i].expY);
            tick();
            expCount++;
            check($sformatf("v%0d_wen_off", i), int'(bus.velocityWriteEnable), 0);
            check($sformatf("v%0d_count", i), int'(bus.shotCount), expCount);
            check($sformatf("v%0d_power_clr", i), int'(bus.power), 0);
            check($sformatf("v%0d_vx_hold", i), int'(bus.outVelocityX), vecs[i].expX);
            if (vecs[i].expX == 0 && vecs[i].expY == 0) begin
                check($sformatf("v%0d_ready_zero", i), int'(bus.shotReady), 1);
            end else begin
                check($sformatf("v%0d_ready_move", i), int'(bus.shotReady), 0);
                frame();
                check($sformatf("v%0d_ready_1f", i), int'(bus.shotReady), 0);
                frame();
                check($sformatf("v%0d_ready_timeout", i), int'(bus.shotReady), 1);
            end
        end

        // Table settles unexpectedly: abort charge.
        bus.shootButton = 1'b1;
        tick();
        for (int f = 0; f < 3; f++) frame();
        check("abort_power_before", int'(bus.power), 12);
        bus.allStopped = 1'b0;
        tick();
        check("abort_power", int'(bus.power), 0);
        check("abort_ready", int'(bus.shotReady), 0);
        bus.shootButton = 1'b0;
        tick();
        check("abort_no_wen", int'(bus.velocityWriteEnable), 0);
        tick();
        check("abort_count", int'(bus.shotCount), expCount);
        bus.allStopped = 1'b1;
        tick();
        check("abort_reaim", int'(bus.shotReady), 1);

        // Reset lands on the FIRE cycle.
        bus.shootButton = 1'b1;
        tick();
        for (int f = 0; f < 5; f++) frame();
        bus.shootButton = 1'b0;
        tick();
        check("rf_wen", int'(bus.velocityWriteEnable), 1);
        reset = 1'b1;
        tick();
        check("rf_wen_off", int'(bus.velocityWriteEnable), 0);
        check("rf_vx",      int'(bus.outVelocityX), 0);
        check("rf_vy",      int'(bus.outVelocityY), 0);
        check("rf_aim",     int'(bus.aimIndex), 0);
        check("rf_power",   int'(bus.power), 0);
        check("rf_ready",   int'(bus.shotReady), 0);
        check("rf_count",   int'(bus.shotCount), 0);
        reset = 1'b0;
        tick();
        check("rf_post_wen", int'(bus.velocityWriteEnable), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shot_controller.md
# shot_controller

Upstream stage of the cue-ball motion block: turns player aim/shoot controls into a single velocity write on the cue ball's velocity-load port. Waits until every ball on the table has stopped, lets the player rotate a 16-step aim direction and charge shot power while the shoot button is held, then issues one `velocityWriteEnable` pulse with the signed X/Y velocity on release. Frame-paced through `startOfFrame`, like the motion blocks it feeds.

## Interface
- `POWER_MAX`, 200: power saturation value; equals the motion block's velocity limit.
- `POWER_STEP`, 4: power increment per frame while charging.
- `AIM_FRAMES`, 6: frames between aim steps while an aim button is held.
- `MOVE_TIMEOUT_FRAMES`, 2: frames to wait for `allStopped` to fall after firing.
- `clk` in 1: system clock; one clock domain.
- `reset` in 1: synchronous, active-high.
- `startOfFrame` in 1: one-cycle pulse per video frame.
- `allStopped` in 1: AND of all balls' `ballStopped`.
- `aimLeft`, `aimRight` in 1 each: level, already debounced.
- `shootButton` in 1: level, already debounced; high = charging.
- `velocityWriteEnable` out 1: one-cycle load strobe to the cue-ball motion block.
- `outVelocityX`, `outVelocityY` out 11 signed: shot velocity in fixed-point units (×64 per pixel per frame).
- `aimIndex` out 4: current direction, 0 = +X, increments counter-clockwise in 22.5° steps (+Y = screen down).
- `power` out 8: current charge, for the power-bar display.
- `shotReady` out 1: high in AIM and CHARGE.
- `shotCount` out 8: completed shots, wraps 255→0.

## Operation
- States: WAIT_STOP, AIM, CHARGE, FIRE, WAIT_MOVE.
- WAIT_STOP: `allStopped` high on any cycle → AIM.
- AIM: on `startOfFrame` with exactly one aim button held, step `aimIndex` ±1 modulo 16. The first step happens on the first frame held, then every `AIM_FRAMES` frames while held. Both buttons held or neither held → no step; the repeat counter clears.
- AIM: `shootButton` high → CHARGE and `power` ← 0.
- CHARGE: on each `startOfFrame`, `power` ← min(`power` + `POWER_STEP`, `POWER_MAX`). `aimIndex` is frozen.
- CHARGE: `shootButton` low → FIRE. That cycle registers vx = (power·cos[aim]) / 64 and vy = (power·sin[aim]) / 64, with signed division truncating toward zero.
  - Table ×64, index 0..15: cos = 64,59,45,24,0,-24,-45,-59,-64,-59,-45,-24,0,24,45,59; sin = cos shifted by 4 indices (0,24,45,59,64,…).
- FIRE (1 cycle): `velocityWriteEnable` = 1; outputs hold vx/vy. `shotCount` increments. `power` ← 0.
  - If vx = vy = 0 (zero power), the write is still issued, then → AIM.
  - Otherwise → WAIT_MOVE.
- WAIT_MOVE: `allStopped` low → WAIT_STOP. Otherwise, after `MOVE_TIMEOUT_FRAMES` `startOfFrame` pulses → WAIT_STOP.
- `allStopped` falling while in AIM or CHARGE → WAIT_STOP. `power` ← 0; no write issued.
- Products are computed 8b unsigned × 8b signed in ≥17-bit signed arithmetic; the result always fits 11 bits signed (|v| ≤ 200).

## Timing
- Reset values: state WAIT_STOP; `velocityWriteEnable` 0, `outVelocityX`/`outVelocityY` 0, `aimIndex` 0, `power` 0, `shotReady` 0, `shotCount` 0.
- Reset asserted mid-operation (including during FIRE) → all of the above on the next edge. No partial write strobe.
- Latency from `shootButton` falling (sampled at edge n) to `velocityWriteEnable` high: edge n+1 (FIRE cycle). The strobe lasts exactly one cycle.
- `outVelocityX`/`outVelocityY` are valid in the FIRE cycle and hold until the next FIRE or reset.
- All outputs are registered. `startOfFrame` coinciding with the release edge: the power increment on that frame is not applied; the shot uses the pre-edge `power`.

## Structure
- Shared package `billiard_pkg`:
  - state enum `shot_state_t`
  - `FIXED_POINT_MULTIPLIER` = 64
  - `VELOCITY_LIMIT` = 200
  - 16-entry signed cos/sin constant arrays
- Sub-module `shot_direction_rom`: combinational, 4-bit index → signed 8-bit cos/sin. It is reused by the cue-stick sprite drawer.

## Test plan
- Reset, raise `allStopped`, hold `shootButton` for 60 frames, release at aim 0 → `power` saturates at 200; one strobe with X=200, Y=0; `shotCount` = 1.
- Hold `aimRight` for 13 frames with `AIM_FRAMES`=6 → `aimIndex` steps at frames 1, 7, 13 (ends at 3). Hold `aimLeft` from index 0 → 15 (wrap). Hold both → unchanged.
- Aim 2, charge 25 frames (power 100), release → X=70, Y=70. Aim 10, same charge → X=-70, Y=-70 (truncation toward zero).
- Press and release `shootButton` between frames (power 0) → strobe with X=Y=0, then back in AIM; `shotReady` high again 2 cycles after release.
- After a valid shot, hold `allStopped` high → WAIT_MOVE times out after 2 frames → WAIT_STOP → AIM. Drop `allStopped` during CHARGE → WAIT_STOP, `power` = 0, no strobe.
- Assert `reset` in the FIRE cycle → no strobe on the following cycle; all outputs at reset values.
